// File: rtl/im_loader.sv
// Program loader: assembles big-endian words from a UART byte stream, writes them
// to consecutive instruction-memory addresses and releases the CPU when loading ends.
module im_loader #(
  parameter int             len       = 32,
  parameter int             NB_BYTE   = 8,
  parameter int             NB_ADDR   = 10,
  parameter logic [len-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_start,
  output logic               o_im_wr_en,
  output logic [NB_ADDR-1:0] o_im_wr_addr,
  output logic [len-1:0]     o_im_wr_data,
  output logic               o_cpu_enable,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic [NB_ADDR:0]   o_word_count
);

  localparam int             LANES = len / NB_BYTE;
  localparam int             CW    = $clog2(LANES);
  localparam logic [NB_ADDR:0] DEPTH = {1'b1, {NB_ADDR{1'b0}}};

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [len-1:0]     shift_q, shift_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [NB_ADDR:0]   wcnt_q, wcnt_d;
  logic               wr_en_q, wr_en_d;
  logic [NB_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [len-1:0]     wr_data_q, wr_data_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, done_q, cpu_en_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wcnt_d    = wcnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          shift_d = {i_rx_data, {(len-NB_BYTE){1'b0}}};
          cnt_d   = CW'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (i_rx_valid) begin
          // Byte number cnt_q lands in lane LANES-1-cnt_q, so the first byte ends up MSB.
          for (int l = 0; l < LANES; l++) begin
            if (cnt_q == CW'(LANES-1-l)) shift_d[l*NB_BYTE +: NB_BYTE] = i_rx_data;
          end
          if (cnt_q == CW'(LANES-1)) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WRITE: begin
        if (shift_q == HALT_WORD) begin
          state_d = DONE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = shift_q;
          addr_d    = addr_q + NB_ADDR'(1);
          wcnt_d    = wcnt_q + (NB_ADDR+1)'(1);
          if (wcnt_d == DEPTH) begin
            state_d = DONE;
            ovf_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        // A strobe in the write cycle opens the next word unless loading just ended.
        if (state_d != DONE && i_rx_valid) begin
          shift_d = {i_rx_data, {(len-NB_BYTE){1'b0}}};
          cnt_d   = CW'(1);
          state_d = COLLECT;
        end
      end
      DONE: begin
        if (i_start) begin
          state_d = IDLE;
          ovf_d   = 1'b0;
          addr_d  = '0;
          wcnt_d  = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wcnt_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cpu_en_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wcnt_q    <= wcnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
      busy_q    <= (state_d == COLLECT) || (state_d == WRITE);
      done_q    <= (state_d == DONE);
      cpu_en_q  <= (state_d == DONE);
    end
  end

  assign o_im_wr_en   = wr_en_q;
  assign o_im_wr_addr = wr_addr_q;
  assign o_im_wr_data = wr_data_q;
  assign o_cpu_enable = cpu_en_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_overflow   = ovf_q;
  assign o_word_count = wcnt_q;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: two instances (1024-word and 4-word memories) share one byte
// stream and are scored against a word-level model of the loading rules.
module tb_im_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int          MAXW = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        start;

  logic [1:0]  wr_en, cpu_en, busy, done, ovf;
  logic [9:0]  addr_a;
  logic [1:0]  addr_b;
  logic [31:0] data_a, data_b;
  logic [10:0] wc_a;
  logic [2:0]  wc_b;

  always #5 clk = ~clk;

  im_loader #(.NB_ADDR(10)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_start(start),
    .o_im_wr_en(wr_en[0]), .o_im_wr_addr(addr_a), .o_im_wr_data(data_a),
    .o_cpu_enable(cpu_en[0]), .o_busy(busy[0]), .o_done(done[0]), .o_overflow(ovf[0]),
    .o_word_count(wc_a)
  );

  im_loader #(.NB_ADDR(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_start(start),
    .o_im_wr_en(wr_en[1]), .o_im_wr_addr(addr_b), .o_im_wr_data(data_b),
    .o_cpu_enable(cpu_en[1]), .o_busy(busy[1]), .o_done(done[1]), .o_overflow(ovf[1]),
    .o_word_count(wc_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_addr(input int k);
    return (k == 0) ? 32'(addr_a) : 32'(addr_b);
  endfunction
  function automatic logic [31:0] f_data(input int k);
    return (k == 0) ? data_a : data_b;
  endfunction
  function automatic logic [31:0] f_wc(input int k);
    return (k == 0) ? 32'(wc_a) : 32'(wc_b);
  endfunction

  // Word-level model: bytes since word start, assembled word, words this load, end flags.
  int          depth [2] = '{1024, 4};
  int          m_idx [2];
  logic [31:0] m_word [2];
  int          m_cnt [2];
  bit          m_done [2];
  bit          m_ovf [2];
  logic [31:0] exp_addr [2][MAXW];
  logic [31:0] exp_data [2][MAXW];
  int          exp_n [2] = '{0, 0};

  logic [31:0] got_addr [2][MAXW];
  logic [31:0] got_data [2][MAXW];
  int          got_n [2] = '{0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wr_en[k] && got_n[k] < MAXW) begin
        got_addr[k][got_n[k]] = f_addr(k);
        got_data[k][got_n[k]] = f_data(k);
        got_n[k]++;
      end
    end
  end

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_word[k] = '0; m_cnt[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
    end
  endtask

  // Entered and left on a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc [2];
    bit wrote [2];
    for (int k = 0; k < 2; k++) begin
      acc[k]   = !m_done[k];
      wrote[k] = 0;
      if (acc[k]) begin
        m_word[k] = {m_word[k][23:0], b};
        m_idx[k]++;
        if (m_idx[k] == 4) begin
          m_idx[k] = 0;
          if (m_word[k] == HALT) begin
            m_done[k] = 1;
          end else begin
            if (exp_n[k] < MAXW) begin
              exp_addr[k][exp_n[k]] = 32'(m_cnt[k]);
              exp_data[k][exp_n[k]] = m_word[k];
              exp_n[k]++;
            end
            wrote[k] = 1;
            m_cnt[k]++;
            if (m_cnt[k] == depth[k]) begin
              m_done[k] = 1;
              m_ovf[k]  = 1;
            end
          end
        end
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("busy_after_byte[%0d]", k), 32'(busy[k]), 32'(acc[k]));
      if (wrote[k]) check($sformatf("wr_en_early[%0d]", k), 32'(wr_en[k]), 0);
    end
    if (gap > 0) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (wrote[k]) check($sformatf("wr_en_latency[%0d]", k), 32'(wr_en[k]), 1);
      repeat (gap - 1) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("busy_in_gap[%0d]", k), 32'(busy[k]), 32'(m_idx[k] != 0));
        check($sformatf("done_in_gap[%0d]", k), 32'(done[k]), 32'(m_done[k]));
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 3; i >= 0; i--)
      send_byte(w[i*8 +: 8], int'($urandom_range(maxgap, 0)));
  endtask

  task automatic settle_and_check(input string tag);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_done[%0d]", tag, k), 32'(done[k]), 32'(m_done[k]));
      check($sformatf("%s_cpu_en[%0d]", tag, k), 32'(cpu_en[k]), 32'(m_done[k]));
      check($sformatf("%s_ovf[%0d]", tag, k), 32'(ovf[k]), 32'(m_ovf[k]));
      check($sformatf("%s_wc[%0d]", tag, k), f_wc(k), 32'(m_cnt[k]));
      check($sformatf("%s_busy[%0d]", tag, k), 32'(busy[k]), 32'(m_idx[k] != 0));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (m_done[k]) begin
        m_done[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0; m_idx[k] = 0;
      end
      check($sformatf("start_cpu_en[%0d]", k), 32'(cpu_en[k]), 0);
      check($sformatf("start_wc[%0d]", k), f_wc(k), 32'(m_cnt[k]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_wr_en[%0d]", k), 32'(wr_en[k]), 0);
      check($sformatf("rst_addr[%0d]", k), f_addr(k), 0);
      check($sformatf("rst_data[%0d]", k), f_data(k), 0);
      check($sformatf("rst_cpu_en[%0d]", k), 32'(cpu_en[k]), 0);
      check($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 0);
      check($sformatf("rst_done[%0d]", k), 32'(done[k]), 0);
      check($sformatf("rst_ovf[%0d]", k), 32'(ovf[k]), 0);
      check($sformatf("rst_wc[%0d]", k), f_wc(k), 0);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    return (w == HALT) ? 32'h0 : w;
  endfunction

  logic [31:0] words [6];

  initial begin
    rst = 1'b0; rx_data = '0; rx_valid = 1'b0; start = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    do_reset();

    // Two program words then the halt word.
    send_word(32'h2008_0005, 1);
    send_word(32'h8C01_0000, 1);
    send_word(HALT, 1);
    settle_and_check("basic");
    check("basic_wc_const", 32'(wc_a), 2);
    check("basic_ovf_const", 32'(ovf[0]), 0);

    // Back-to-back strobes: each new word starts in the previous write cycle.
    pulse_start();
    send_word(32'hAABB_CCDD, 0);
    send_word(32'h1122_3344, 0);
    send_word(32'h5566_7788, 0);
    send_word(HALT, 0);
    settle_and_check("b2b");

    // Fill the 4-word instance; later bytes must be ignored there.
    pulse_start();
    for (int i = 0; i < 6; i++) send_word(rand_word(), 1);
    settle_and_check("fill");
    check("fill_ovf_const", 32'(ovf[1]), 1);
    check("fill_wc_const", 32'(wc_b), 4);
    send_word(HALT, 1);
    settle_and_check("fill_end");

    // Reset after a partial word, then one fresh word and halt.
    pulse_start();
    send_byte(8'h5A, 1);
    send_byte(8'hA5, 2);
    do_reset();
    send_word(32'h1122_3344, 1);
    send_word(HALT, 1);
    settle_and_check("rst_mid");

    // Same words without and with random 0..50 cycle gaps.
    for (int i = 0; i < 6; i++) words[i] = rand_word();
    pulse_start();
    for (int i = 0; i < 6; i++) send_word(words[i], 0);
    send_word(HALT, 1);
    settle_and_check("nogap");
    pulse_start();
    for (int i = 0; i < 6; i++) send_word(words[i], 50);
    send_word(HALT, 2);
    settle_and_check("gaps");

    repeat (4) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("write_count[%0d]", k), 32'(got_n[k]), 32'(exp_n[k]));
      for (int i = 0; i < exp_n[k] && i < got_n[k]; i++) begin
        check($sformatf("wr_addr[%0d][%0d]", k, i), got_addr[k][i], exp_addr[k][i]);
        check($sformatf("wr_data[%0d][%0d]", k, i), got_data[k][i], exp_data[k][i]);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
